// File: rtl/uart_pwm_pkg.sv
// Shared types and constants for the UART-to-PWM framing path.
// No logic; the helper turns a clock rate and a millisecond budget into cycles.
// Imported by the framer and the timeout counter.
package uart_pwm_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
  localparam int         CLK_FREQ_HZ    = 27_000_000;

  // Divide first so 27 MHz * 10 ms stays well inside 32-bit range.
  function automatic int timeout_cycles(input int clk_hz, input int timeout_ms);
    return (clk_hz / 1000) * timeout_ms;
  endfunction

endpackage

// File: rtl/frame_timeout_ctr.sv
// Inter-byte watchdog: counts idle cycles while run is high, cleared by kick.
// expired is combinational, high in the cycle the count sits at LIMIT-1 with no kick.
// No backpressure; kick wins over expiry in the same cycle.
module frame_timeout_ctr
#(
  parameter int LIMIT = 270000
)(
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic kick,
  output logic expired
);

  localparam int             CW   = $clog2(LIMIT);
  localparam logic [CW-1:0]  LAST = CW'(LIMIT - 1);

  logic [CW-1:0] r_cnt;

  // Count idle cycles; hold at LAST so a stalled frame can never wrap back to zero.
  always_ff @(posedge clk) begin
    if (!rst_n || !run || kick) begin
      r_cnt <= '0;
    end else if (r_cnt != LAST) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign expired = run && !kick && (r_cnt == LAST);

endmodule

// File: rtl/uart_frame_to_pwm.sv
// Frames HEADER,P0..Pn-1,CHK bytes from the UART into a checked PWM word.
// Output word and word_valid/frame_err pulses appear one cycle after the CHK strobe.
// No backpressure: every rx_valid strobe is consumed in its own cycle.
module uart_frame_to_pwm
  import uart_pwm_pkg::*;
#(
  parameter logic [7:0]             HEADER         = HEADER_DEFAULT,
  parameter int                     NUM_BYTES      = 4,
  parameter int                     TIMEOUT_CYCLES = timeout_cycles(CLK_FREQ_HZ, 10),
  parameter logic [8*NUM_BYTES-1:0] RESET_WORD     = '0
)(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic [8*NUM_BYTES-1:0] bytes_to_pwm_x,
  output logic                   word_valid,
  output logic                   frame_err,
  output logic                   busy
);

  localparam int             W         = 8 * NUM_BYTES;
  localparam int             BCW       = $clog2(NUM_BYTES + 1);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NUM_BYTES - 1);

  state_t         r_state;
  logic [W-1:0]   r_shift;
  logic [7:0]     r_chk;
  logic [BCW-1:0] r_bcnt;
  logic [W-1:0]   r_word;
  logic           r_word_valid;
  logic           r_frame_err;

  state_t         w_state_nxt;
  logic [W-1:0]   w_shift_nxt;
  logic [7:0]     w_chk_nxt;
  logic [BCW-1:0] w_bcnt_nxt;
  logic [W-1:0]   w_word_nxt;
  logic           w_word_valid_nxt;
  logic           w_frame_err_nxt;
  logic           w_run;
  logic           w_expired;

  assign w_run = (r_state != HUNT);

  frame_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (w_run),
    .kick    (rx_valid),
    .expired (w_expired)
  );

  // Next-state and datapath decode; a received byte always takes precedence over expiry.
  always_comb begin
    w_state_nxt      = r_state;
    w_shift_nxt      = r_shift;
    w_chk_nxt        = r_chk;
    w_bcnt_nxt       = r_bcnt;
    w_word_nxt       = r_word;
    w_word_valid_nxt = 1'b0;
    w_frame_err_nxt  = 1'b0;
    case (r_state)
      HUNT: begin
        if (rx_valid && (rx_data == HEADER)) begin
          w_state_nxt = PAYLOAD;
          w_shift_nxt = '0;
          w_chk_nxt   = '0;
          w_bcnt_nxt  = '0;
        end
      end
      PAYLOAD: begin
        if (rx_valid) begin
          // HEADER-valued bytes are plain data here; no resync mid-frame.
          w_shift_nxt = W'({r_shift, rx_data});
          w_chk_nxt   = r_chk ^ rx_data;
          w_bcnt_nxt  = r_bcnt + BCW'(1);
          if (r_bcnt == LAST_BYTE) begin
            w_state_nxt = CHECK;
          end
        end else if (w_expired) begin
          w_state_nxt     = HUNT;
          w_frame_err_nxt = 1'b1;
        end
      end
      CHECK: begin
        if (rx_valid) begin
          if (rx_data == r_chk) begin
            w_word_nxt       = r_shift;
            w_word_valid_nxt = 1'b1;
          end else begin
            w_frame_err_nxt  = 1'b1;
          end
          w_state_nxt = HUNT;
        end else if (w_expired) begin
          w_state_nxt     = HUNT;
          w_frame_err_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = HUNT;
      end
    endcase
  end

  // State and datapath registers; reset drops any partial frame without flagging it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= HUNT;
      r_shift      <= '0;
      r_chk        <= '0;
      r_bcnt       <= '0;
      r_word       <= RESET_WORD;
      r_word_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_chk        <= w_chk_nxt;
      r_bcnt       <= w_bcnt_nxt;
      r_word       <= w_word_nxt;
      r_word_valid <= w_word_valid_nxt;
      r_frame_err  <= w_frame_err_nxt;
    end
  end

  assign bytes_to_pwm_x = r_word;
  assign word_valid     = r_word_valid;
  assign frame_err      = r_frame_err;
  assign busy           = w_run;

endmodule

// File: tb/tb_uart_frame_to_pwm.sv
// Directed bench for uart_frame_to_pwm: frame table plus timeout/reset/back-to-back sequences.
// Inputs driven on the falling edge, outputs sampled on the falling edge or 1 time unit after rising.
// Short timeout parameter keeps the run to a few hundred cycles.
module tb_uart_frame_to_pwm;

  localparam int T = 20;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] bytes_to_pwm_x;
  logic        word_valid;
  logic        frame_err;
  logic        busy;

  int n_checks   = 0;
  int n_err      = 0;
  int n_wv       = 0;
  int n_fe       = 0;
  int n_overlap  = 0;
  int n_unstable = 0;
  logic [31:0] prev_word = 32'h0;

  typedef struct {
    logic [47:0] frame;
    logic [31:0] exp_word;
    int          exp_wv;
    int          exp_fe;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  uart_frame_to_pwm #(
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .bytes_to_pwm_x (bytes_to_pwm_x),
    .word_valid     (word_valid),
    .frame_err      (frame_err),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters and invariants, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (word_valid) n_wv++;
    if (frame_err) n_fe++;
    if (word_valid && frame_err) n_overlap++;
    if (rst_n && !word_valid && (bytes_to_pwm_x !== prev_word)) n_unstable++;
    prev_word = bytes_to_pwm_x;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [47:0] f);
    for (int i = 5; i >= 0; i--) send_byte(f[i*8 +: 8]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wv0;
    int fe0;
    int found;

    vecs[0] = '{48'hA5_12345678_08, 32'h12345678, 1, 0};
    vecs[1] = '{48'hA5_DEADBEEF_00, 32'h12345678, 0, 1};
    vecs[2] = '{48'hA5_3CC35AA5_00, 32'h3CC35AA5, 1, 0};
    vecs[3] = '{48'hA5_00000001_01, 32'h00000001, 1, 0};
    vecs[4] = '{48'hA5_FFFFFFFF_00, 32'hFFFFFFFF, 1, 0};
    vecs[5] = '{48'hA5_80000001_81, 32'h80000001, 1, 0};
    vecs[6] = '{48'hA5_12345678_09, 32'h80000001, 0, 1};

    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(4);
    check("reset word", bytes_to_pwm_x, 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset word_valid pulses", n_wv, 0);
    check("reset frame_err pulses", n_fe, 0);

    // Table of complete frames with a short idle gap between them.
    for (int i = 0; i < NV; i++) begin
      wv0 = n_wv;
      fe0 = n_fe;
      send_frame(vecs[i].frame);
      if (vecs[i].exp_wv == 1) check($sformatf("vec%0d word_valid after chk", i), 32'(word_valid), 32'h1);
      tick(2);
      check($sformatf("vec%0d word", i), bytes_to_pwm_x, vecs[i].exp_word);
      check($sformatf("vec%0d word_valid count", i), n_wv - wv0, vecs[i].exp_wv);
      check($sformatf("vec%0d frame_err count", i), n_fe - fe0, vecs[i].exp_fe);
      check($sformatf("vec%0d busy idle", i), 32'(busy), 32'h0);
    end

    // Timeout in PAYLOAD: frame_err exactly T cycles after the last byte.
    fe0 = n_fe;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h02);
    found = 0;
    for (int k = 1; k <= 3 * T && found == 0; k++) begin
      @(negedge clk);
      if (k == 1) check("timeout busy during stall", 32'(busy), 32'h1);
      if (frame_err) found = k;
    end
    check("timeout latency", found, T);
    tick(2);
    check("timeout frame_err count", n_fe - fe0, 1);
    check("timeout busy dropped", 32'(busy), 32'h0);
    check("timeout word kept", bytes_to_pwm_x, 32'h80000001);
    send_frame(48'hA5_00000001_01);
    tick(1);
    check("after timeout word", bytes_to_pwm_x, 32'h00000001);

    // Byte landing on the limit cycle cancels the timeout.
    wv0 = n_wv;
    fe0 = n_fe;
    send_byte(8'hA5);
    send_byte(8'h11);
    tick(T - 1);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h44);
    tick(1);
    check("limit byte word", bytes_to_pwm_x, 32'h11223344);
    check("limit byte frame_err count", n_fe - fe0, 0);
    check("limit byte word_valid count", n_wv - wv0, 1);

    // HEADER in the cycle right after CHK starts the next frame.
    wv0 = n_wv;
    send_frame(48'hA5_00000002_02);
    send_frame(48'hA5_00000003_03);
    tick(1);
    check("back-to-back word", bytes_to_pwm_x, 32'h00000003);
    check("back-to-back word_valid count", n_wv - wv0, 2);

    // Noise ignored, then HEADER-valued payload bytes with no gaps.
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    check("noise busy", 32'(busy), 32'h0);
    send_frame(48'hA5_A5A5A5A5_00);
    tick(1);
    check("header payload word", bytes_to_pwm_x, 32'hA5A5A5A5);

    // Reset mid-frame discards it silently.
    fe0 = n_fe;
    send_byte(8'hA5);
    send_byte(8'h11);
    send_byte(8'h22);
    rst_n = 1'b0;
    tick(2);
    check("mid reset word", bytes_to_pwm_x, 32'h0);
    check("mid reset busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    tick(1);
    send_frame(48'hA5_00000010_10);
    tick(2);
    check("post reset word", bytes_to_pwm_x, 32'h00000010);
    check("mid reset frame_err count", n_fe - fe0, 0);

    check("word_valid/frame_err overlap", n_overlap, 0);
    check("word stable between pulses", n_unstable, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
